// File: rtl/enable_burst_pkg.sv
// Shared types and defaults for the enable burst generator.
package enable_burst_pkg;

  localparam int CNT_W_DEF   = 8;
  localparam int PRESC_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } state_t;

  // State entered when a burst is (re)loaded: skip DELAY/BURST when their count is zero.
  function automatic state_t first_state(input logic delay_nz, input logic burst_nz);
    if (delay_nz) begin
      return DELAY;
    end else if (burst_nz) begin
      return BURST;
    end else begin
      return DONE;
    end
  endfunction

endpackage

// File: rtl/enable_burst_gen_tick_prescaler.sv
// Free-running 0..div counter; tick is high whenever the count is zero, clr holds it at zero.
module tick_prescaler #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] div,
  output logic         tick
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr || (cnt_q >= div)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/enable_burst_gen.sv
// Delay-then-burst enable source for the down counter: waits delay_cycles, emits burst_len
// prescaled enable ticks, pulses done. ENABLE_BURST_REPEAT_EN adds repeat_mode (auto-restart).
module enable_burst_gen
  import enable_burst_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
`ifdef ENABLE_BURST_REPEAT_EN
  input  logic               repeat_mode,
`endif
  input  logic [CNT_W-1:0]   delay_cycles,
  input  logic [CNT_W-1:0]   burst_len,
  input  logic [PRESC_W-1:0] presc_div,
  output logic               enable,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   ticks_left
);

  state_t               state_q;
  logic [CNT_W-1:0]     dly_q;
  logic [CNT_W-1:0]     ticks_q;
  logic [CNT_W-1:0]     burst_q;
  logic [PRESC_W-1:0]   presc_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 presc_tick;
`ifdef ENABLE_BURST_REPEAT_EN
  logic [CNT_W-1:0]     dcfg_q;
  logic                 rpt_q;
`endif

  // Prescaler sits at zero outside BURST so the first BURST cycle always ticks.
  tick_prescaler #(
    .W(PRESC_W)
  ) u_presc (
    .clock (clock),
    .reset (reset),
    .clr   (state_q != BURST),
    .div   (presc_q),
    .tick  (presc_tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dly_q   <= '0;
      ticks_q <= '0;
      burst_q <= '0;
      presc_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ENABLE_BURST_REPEAT_EN
      dcfg_q  <= '0;
      rpt_q   <= 1'b0;
`endif
    end else if (abort) begin
      state_q <= IDLE;
      dly_q   <= '0;
      ticks_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            dly_q   <= delay_cycles;
            ticks_q <= burst_len;
            burst_q <= burst_len;
            presc_q <= presc_div;
`ifdef ENABLE_BURST_REPEAT_EN
            dcfg_q  <= delay_cycles;
            rpt_q   <= repeat_mode;
`endif
            state_q <= first_state(delay_cycles != '0, burst_len != '0);
            busy_q  <= 1'b1;
            done_q  <= (delay_cycles == '0) && (burst_len == '0);
          end
        end
        DELAY: begin
          if (dly_q <= CNT_W'(1)) begin
            dly_q   <= '0;
            state_q <= (burst_q != '0) ? BURST : DONE;
            done_q  <= (burst_q == '0);
          end else begin
            dly_q <= dly_q - CNT_W'(1);
          end
        end
        BURST: begin
          if (presc_tick) begin
            if (ticks_q != '0) begin
              ticks_q <= ticks_q - CNT_W'(1);
            end
            if (ticks_q <= CNT_W'(1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
`ifdef ENABLE_BURST_REPEAT_EN
          if (rpt_q) begin
            dly_q   <= dcfg_q;
            ticks_q <= burst_q;
            state_q <= first_state(dcfg_q != '0, burst_q != '0);
            done_q  <= (dcfg_q == '0) && (burst_q == '0);
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
`else
          state_q <= IDLE;
          busy_q  <= 1'b0;
`endif
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign enable     = (state_q == BURST) && presc_tick;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ticks_left = ticks_q;

endmodule

// File: tb/tb_enable_burst_gen.sv
// Directed bench for enable_burst_gen; observes {enable,busy,done,ticks_left} one ns after each edge.
module tb_enable_burst_gen;

  logic       clock;
  logic       reset;
  logic       start;
  logic       abort;
`ifdef ENABLE_BURST_REPEAT_EN
  logic       repeat_mode;
`endif
  logic [7:0] delay_cycles;
  logic [7:0] burst_len;
  logic [3:0] presc_div;
  logic       enable;
  logic       busy;
  logic       done;
  logic [7:0] ticks_left;
  logic [10:0] obs;

  int vectors = 0;
  int fails   = 0;

  enable_burst_gen dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
`ifdef ENABLE_BURST_REPEAT_EN
    .repeat_mode  (repeat_mode),
`endif
    .delay_cycles (delay_cycles),
    .burst_len    (burst_len),
    .presc_div    (presc_div),
    .enable       (enable),
    .busy         (busy),
    .done         (done),
    .ticks_left   (ticks_left)
  );

  assign obs = {enable, busy, done, ticks_left};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [10:0] pk(input logic en, input logic b, input logic d,
                                      input logic [7:0] t);
    return {en, b, d, t};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input logic [7:0] dly, input logic [7:0] len, input logic [3:0] pd);
    delay_cycles = dly;
    burst_len    = len;
    presc_div    = pd;
    start        = 1'b1;
    step();
    start        = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    vectors++;
    if (obs !== pk(0, 0, 0, 0)) begin
      fails++;
      $display("FAIL reset_async: got %h want %h", obs, pk(0, 0, 0, 0));
    end
    step();
    reset = 1'b0;
    step();
    vectors++;
    if (obs !== pk(0, 0, 0, 0)) begin
      fails++;
      $display("FAIL reset_idle: got %h want %h", obs, pk(0, 0, 0, 0));
    end
  endtask

  task automatic test_burst3();
    logic [10:0] exp;
    launch(8'd0, 8'd3, 4'd0);
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: exp = pk(1, 1, 0, 3);
        1: exp = pk(1, 1, 0, 2);
        2: exp = pk(1, 1, 0, 1);
        3: exp = pk(0, 1, 1, 0);
        default: exp = pk(0, 0, 0, 0);
      endcase
      vectors++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL burst3 c%0d: got %h want %h", c, obs, exp);
      end
      step();
    end
  endtask

  task automatic test_delay_presc();
    int tk[10] = '{4, 3, 3, 3, 2, 2, 2, 1, 1, 1};
    int n_en = 0;
    logic [10:0] exp;
    launch(8'd5, 8'd4, 4'd2);
    // Data inputs changed mid-operation must be ignored.
    delay_cycles = 8'd1;
    burst_len    = 8'd9;
    presc_div    = 4'd0;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (obs !== pk(0, 1, 0, 4)) begin
        fails++;
        $display("FAIL delay5 c%0d: got %h want %h", c, obs, pk(0, 1, 0, 4));
      end
      step();
    end
    for (int c = 0; c < 10; c++) begin
      exp = pk((c % 3) == 0, 1, 0, 8'(tk[c]));
      if (enable === 1'b1) n_en++;
      vectors++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL presc2 c%0d: got %h want %h", c, obs, exp);
      end
      step();
    end
    vectors++;
    if (obs !== pk(0, 1, 1, 0)) begin
      fails++;
      $display("FAIL presc2_done: got %h want %h", obs, pk(0, 1, 1, 0));
    end
    vectors++;
    if (n_en != 4) begin
      fails++;
      $display("FAIL presc2_count: got %0d want 4", n_en);
    end
    step();
    vectors++;
    if (obs !== pk(0, 0, 0, 0)) begin
      fails++;
      $display("FAIL presc2_idle: got %h want %h", obs, pk(0, 0, 0, 0));
    end
  endtask

  task automatic test_zero_burst();
    logic [10:0] exp;
    launch(8'd2, 8'd0, 4'd0);
    for (int c = 0; c < 4; c++) begin
      exp = (c < 2) ? pk(0, 1, 0, 0) : (c == 2) ? pk(0, 1, 1, 0) : pk(0, 0, 0, 0);
      vectors++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL zero_burst c%0d: got %h want %h", c, obs, exp);
      end
      step();
    end
  endtask

  task automatic test_abort();
    logic [10:0] exp;
    launch(8'd0, 8'd10, 4'd0);
    vectors++;
    if (obs !== pk(1, 1, 0, 10)) begin
      fails++;
      $display("FAIL abort_tick1: got %h want %h", obs, pk(1, 1, 0, 10));
    end
    step();
    vectors++;
    if (obs !== pk(1, 1, 0, 9)) begin
      fails++;
      $display("FAIL abort_tick2: got %h want %h", obs, pk(1, 1, 0, 9));
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int c = 0; c < 2; c++) begin
      vectors++;
      if (obs !== pk(0, 0, 0, 0)) begin
        fails++;
        $display("FAIL abort_after c%0d: got %h want %h", c, obs, pk(0, 0, 0, 0));
      end
      step();
    end
    launch(8'd0, 8'd2, 4'd0);
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: exp = pk(1, 1, 0, 2);
        1: exp = pk(1, 1, 0, 1);
        2: exp = pk(0, 1, 1, 0);
        default: exp = pk(0, 0, 0, 0);
      endcase
      vectors++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL abort_restart c%0d: got %h want %h", c, obs, exp);
      end
      step();
    end
  endtask

  task automatic test_start_abort_reset();
    delay_cycles = 8'd0;
    burst_len    = 8'd3;
    start        = 1'b1;
    abort        = 1'b1;
    step();
    step();
    start = 1'b0;
    abort = 1'b0;
    vectors++;
    if (obs !== pk(0, 0, 0, 0)) begin
      fails++;
      $display("FAIL start_abort: got %h want %h", obs, pk(0, 0, 0, 0));
    end
    launch(8'd5, 8'd3, 4'd0);
    step();
    vectors++;
    if (obs !== pk(0, 1, 0, 3)) begin
      fails++;
      $display("FAIL pre_reset_delay: got %h want %h", obs, pk(0, 1, 0, 3));
    end
    #3 reset = 1'b1;
    #1;
    vectors++;
    if (obs !== pk(0, 0, 0, 0)) begin
      fails++;
      $display("FAIL reset_mid_delay: got %h want %h", obs, pk(0, 0, 0, 0));
    end
    step();
    reset = 1'b0;
    step();
    step();
    vectors++;
    if (obs !== pk(0, 0, 0, 0)) begin
      fails++;
      $display("FAIL post_reset_idle: got %h want %h", obs, pk(0, 0, 0, 0));
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp;
    delay_cycles = 8'd0;
    burst_len    = 8'd1;
    presc_div    = 4'd0;
    start        = 1'b1;
    step();
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: exp = pk(1, 1, 0, 1);
        1: exp = pk(0, 1, 1, 0);
        2: exp = pk(0, 0, 0, 0);
        default: exp = pk(1, 1, 0, 1);
      endcase
      vectors++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL back_to_back c%0d: got %h want %h", c, obs, exp);
      end
      if (c == 3) start = 1'b0;
      step();
    end
    step();
    vectors++;
    if (obs !== pk(0, 0, 0, 0)) begin
      fails++;
      $display("FAIL back_to_back_end: got %h want %h", obs, pk(0, 0, 0, 0));
    end
  endtask

  task automatic test_repeat();
    logic [10:0] exp;
`ifdef ENABLE_BURST_REPEAT_EN
    repeat_mode = 1'b1;
`endif
    launch(8'd1, 8'd2, 4'd0);
`ifdef ENABLE_BURST_REPEAT_EN
    repeat_mode = 1'b0;
    for (int c = 0; c < 12; c++) begin
`else
    for (int c = 0; c < 7; c++) begin
`endif
      case (c % 4)
        0: exp = pk(0, 1, 0, 2);
        1: exp = pk(1, 1, 0, 2);
        2: exp = pk(1, 1, 0, 1);
        default: exp = pk(0, 1, 1, 0);
      endcase
`ifndef ENABLE_BURST_REPEAT_EN
      if (c >= 4) exp = pk(0, 0, 0, 0);
`endif
      vectors++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL repeat c%0d: got %h want %h", c, obs, exp);
      end
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    vectors++;
    if (obs !== pk(0, 0, 0, 0)) begin
      fails++;
      $display("FAIL repeat_end: got %h want %h", obs, pk(0, 0, 0, 0));
    end
  endtask

  initial begin
    start        = 1'b0;
    abort        = 1'b0;
    delay_cycles = 8'd0;
    burst_len    = 8'd0;
    presc_div    = 4'd0;
`ifdef ENABLE_BURST_REPEAT_EN
    repeat_mode  = 1'b0;
`endif
    test_reset();
    test_burst3();
    test_delay_presc();
    test_zero_burst();
    test_abort();
    test_start_abort_reset();
    test_back_to_back();
    test_repeat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/enable_burst_gen.md
Name: enable_burst_gen

Overview:
- Upstream stage of the 8-bit synchronous down counter; drives that counter's enable input.
- On a start request it waits a programmable delay, then emits a programmable number of enable ticks at a prescaled rate.
- It then pulses done and returns to idle.
- Gives software-free, cycle-exact control of how far the down counter decrements.

Parameters:
- CNT_W, 8, width of delay_cycles, burst_len and ticks_left; matches the counter width.
- PRESC_W, 4, width of the prescaler divide field.

Ports:
- clock  input  1  rising-edge clock shared with the down counter.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a burst; sampled only in IDLE.
- abort  input  1  cancel any operation; sampled in every state.
- delay_cycles  input  CNT_W  clocks to wait before the burst.
- burst_len  input  CNT_W  number of enable ticks to emit.
- presc_div  input  PRESC_W  tick spacing minus one (0 gives a tick every clock).
- enable  output  1  tick to the down counter's enable.
- busy  output  1  high in DELAY, BURST and DONE.
- done  output  1  one-cycle pulse at burst completion.
- ticks_left  output  CNT_W  enable ticks still to be emitted.

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-high (reset).
- Reset values: all outputs 0; state IDLE; internal counters 0.
- Outputs decode from registers only; there is no combinational path from any input to any output.
- States: IDLE, DELAY, BURST, DONE.
- IDLE:
  - start=1 at edge k latches delay_cycles, burst_len and presc_div.
  - ticks_left loads burst_len.
  - Next state: DELAY if delay_cycles!=0; else BURST if burst_len!=0; else DONE.
- DELAY:
  - Stays exactly delay_cycles clocks.
  - Then goes to BURST, or to DONE if the latched burst_len==0.
- BURST:
  - Prescaler counts 0..presc_div and wraps.
  - enable=1 when the prescaler is 0, so the first tick comes in the first BURST cycle.
  - Each enable cycle decrements ticks_left.
  - The cycle after the tick that takes ticks_left to 0, state becomes DONE.
  - Tick spacing is presc_div+1 clocks.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- Example: delay=0, presc=0, burst=3, start at edge k:
  - enable high after edges k, k+1, k+2.
  - done high after edge k+3.
  - IDLE after edge k+4.
  - Total: burst_len enable cycles, no gaps.
- Inputs are ignored outside IDLE except abort; changing the data inputs mid-burst has no effect.
- abort=1 in any state: next state IDLE; enable, busy and ticks_left go to 0 at that edge; done is not pulsed.
- abort and start in the same cycle: abort wins; the block stays IDLE.
- start held high: a new burst begins on the first IDLE cycle after DONE, i.e. back-to-back bursts with one IDLE gap.
- Async reset mid-burst clears everything immediately; no done pulse.
- Counters never wrap: ticks_left stops at 0 and the delay counter stops at 0.

Optional Feature:
- Macro: ENABLE_BURST_REPEAT_EN.
- Defined:
  - Adds input port repeat_mode (1 bit), latched with start.
  - When latched repeat_mode=1, DONE goes back to DELAY instead of IDLE, reloading the latched delay and burst_len and restarting the prescaler.
  - done still pulses once per burst.
  - Only abort or reset ends the sequence.
- Undefined: port absent; DONE always returns to IDLE.

Decomposition:
- Package enable_burst_pkg contains:
  - state enum typedef (IDLE, DELAY, BURST, DONE), 2-bit encoding;
  - default CNT_W and PRESC_W localparams.
- One natural sub-module, tick_prescaler:
  - ports clock, reset, clr, div, tick;
  - free-running 0..div counter;
  - clr forces 0;
  - tick=1 when the count is 0.

Test Plan:
- delay=0, presc=0, burst=3, single start pulse -> enable high exactly 3 consecutive cycles; done one cycle later; busy for 4 cycles; ticks_left 3,2,1,0.
- delay=5, presc=2, burst=4 -> 5 idle-busy cycles, then enables at BURST cycles 0,3,6,9; done the cycle after the fourth tick; the 8-bit down counter drops by exactly 4.
- burst=0, delay=2 -> no enable ever; done after 2 DELAY cycles plus one DONE cycle.
- abort asserted on the 2nd tick of a burst=10 -> enable low from the next cycle; busy=0; no done; ticks_left=0; a new start works normally.
- start and abort high together in IDLE -> stays IDLE, busy=0; reset asserted mid-DELAY -> all outputs 0 immediately (asynchronously), state IDLE.
- With ENABLE_BURST_REPEAT_EN and repeat_mode=1, delay=1, burst=2 -> done pulses every 4 cycles until abort; with the macro undefined -> a single burst only.
